// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control.
// Detects load-use and no-forwarding data hazards between the ID sources and
// the in-flight EXE/MEM destinations, turns taken branches into IF/ID flushes,
// and holds the pipeline while a long-latency EXE op (mul/div) completes.
// Control outputs are Mealy (combinational from state and inputs).
// Also keeps a saturating count of frozen cycles for performance bring-up.
module hazard_ctrl #(
    parameter int LONG_STALL = 4    // extra EXE cycles for a long op, 2..15
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic [4:0]  Src1_ID,
    input  logic [4:0]  Src2_ID,
    input  logic        Two_src_ID,
    input  logic [4:0]  Dst_EXE,
    input  logic        WB_EN_EXE,
    input  logic        MEM_R_EN_EXE,
    input  logic [4:0]  Dst_MEM,
    input  logic        WB_EN_MEM,
    input  logic        Forward_EN,
    input  logic        Br_taken_ID,
    input  logic        Long_op_EXE,
    input  logic        Cnt_clr,
    output logic        Freeze,
    output logic        Flush_IFID,
    output logic        Flush_IDEXE,
    output logic        Hold_EXE,
    output logic        Bubble_MEM,
    output logic        Busy,
    output logic [15:0] Stall_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The IDLE cycle that sees the long op is itself a stall cycle, so BUSY
    // only has to cover the remaining LONG_STALL-1 cycles (cnt runs down to 0).
    localparam logic [3:0] CNT_LOAD = 4'(LONG_STALL - 2);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        long_stall;
    logic        data_hazard;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    // True when either live ID source reads the given destination.
    function automatic logic src_hit(input logic [4:0] dst);
        return reg_match(Src1_ID, dst) || (Two_src_ID && reg_match(Src2_ID, dst));
    endfunction

    // Hazard detection: with forwarding only a load in EXE cannot be bypassed;
    // without forwarding any pending write in EXE or MEM must drain first.
    always_comb begin
        if (Forward_EN) begin
            data_hazard = MEM_R_EN_EXE && WB_EN_EXE && src_hit(Dst_EXE);
        end else begin
            data_hazard = (WB_EN_EXE && src_hit(Dst_EXE)) ||
                          (WB_EN_MEM && src_hit(Dst_MEM));
        end
    end

    // Long-op sequencer: IDLE -> BUSY (count down) -> DONE -> IDLE.
    // DONE ignores Long_op_EXE because the same op is advancing out of EXE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Long_op_EXE) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign long_stall = ((state_q == ST_IDLE) && Long_op_EXE) || (state_q == ST_BUSY);

    // Output priority: long stall, then data hazard, then taken branch.
    // Everything is forced low while reset is held.
    always_comb begin
        Freeze      = 1'b0;
        Flush_IFID  = 1'b0;
        Flush_IDEXE = 1'b0;
        Hold_EXE    = 1'b0;
        Bubble_MEM  = 1'b0;
        Busy        = 1'b0;
        if (rst) begin
            if (long_stall) begin
                Freeze     = 1'b1;
                Hold_EXE   = 1'b1;
                Bubble_MEM = 1'b1;
                Busy       = 1'b1;
            end else if (data_hazard) begin
                // Branch operands may be stale; the branch re-evaluates next cycle.
                Freeze      = 1'b1;
                Flush_IDEXE = 1'b1;
            end else if (Br_taken_ID) begin
                Flush_IFID = 1'b1;
            end
        end
    end

    // Stall cycle counter: clear wins, otherwise count frozen cycles and saturate.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Cnt_clr) begin
            stall_cnt_d = 16'd0;
        end else if (Freeze && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_cnt = stall_cnt_q;

endmodule
